// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Instruction-fetch sequencer. Owns the PC, runs the instruction
//            memory req/ack handshake and buffers fetched words for decode
//            in a two-entry queue (head + skid). Handles stall, branch
//            redirect (head kept as delay slot) and exception flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ce;
    logic [ADDR_W-1:0] r_pc;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_inst;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_skid_inst;
    logic [ADDR_W-1:0] r_skid_pc;

    logic              w_consume;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_take;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_credit;
    logic              w_head_v;
    logic [DATA_W-1:0] w_head_inst;
    logic [ADDR_W-1:0] w_head_pc;
    logic              w_skid_v;
    logic [DATA_W-1:0] w_skid_inst;
    logic [ADDR_W-1:0] w_skid_pc;

    assign w_consume  = r_if_valid & ~stall_i;
    assign w_redirect = flush_i | branch_flag_i;
    // Flush beats branch; targets are forced word-aligned.
    assign w_target   = (flush_i ? new_pc_i : branch_target_i) & ~ADDR_W'(3);
    // An acked word is only kept when no redirect lands in the same cycle.
    assign w_take     = (r_state == S_REQ) & r_mem_req & mem_ack & ~w_redirect;
    assign w_next_pc  = w_redirect ? w_target :
                        (w_take ? (r_pc + ADDR_W'(PC_STEP)) : r_pc);
    // One more request may be outstanding only if the queue will not be full.
    assign w_credit   = ~(w_head_v & w_skid_v);

    // Next queue contents: consume/shift, enqueue, and redirect drops.
    always_comb begin
        w_head_v    = r_if_valid;
        w_head_inst = r_if_inst;
        w_head_pc   = r_if_pc;
        w_skid_v    = r_skid_v;
        w_skid_inst = r_skid_inst;
        w_skid_pc   = r_skid_pc;
        if (flush_i) begin
            w_head_v = 1'b0;
            w_skid_v = 1'b0;
        end else if (branch_flag_i) begin
            w_skid_v = 1'b0;
            if (w_consume) begin
                w_head_v = 1'b0;
            end
        end else begin
            if (w_consume) begin
                w_head_v    = r_skid_v;
                w_head_inst = r_skid_inst;
                w_head_pc   = r_skid_pc;
                w_skid_v    = 1'b0;
            end
            if (w_take) begin
                if (!w_head_v) begin
                    w_head_v    = 1'b1;
                    w_head_inst = mem_rdata;
                    w_head_pc   = r_mem_addr;
                end else begin
                    w_skid_v    = 1'b1;
                    w_skid_inst = mem_rdata;
                    w_skid_pc   = r_mem_addr;
                end
            end
        end
    end

    // Fetch FSM, PC and queue registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ce        <= 1'b0;
            r_pc        <= RESET_PC;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_if_valid  <= 1'b0;
            r_if_inst   <= '0;
            r_if_pc     <= '0;
            r_skid_v    <= 1'b0;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_ce        <= 1'b1;
            r_pc        <= w_next_pc;
            r_if_valid  <= w_head_v;
            r_if_inst   <= w_head_inst;
            r_if_pc     <= w_head_pc;
            r_skid_v    <= w_skid_v;
            r_skid_inst <= w_skid_inst;
            r_skid_pc   <= w_skid_pc;
            case (r_state)
                S_IDLE: begin
                    if (r_ce && w_credit) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_next_pc;
                    end
                end
                S_REQ: begin
                    if (!mem_ack) begin
                        // Request stays on the bus; its word is dead if redirected.
                        if (w_redirect) begin
                            r_state <= S_DISCARD;
                        end
                    end else if (w_credit) begin
                        r_mem_addr <= w_next_pc;
                    end else begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        if (w_credit) begin
                            r_state    <= S_REQ;
                            r_mem_addr <= w_next_pc;
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign ce       = r_ce;
    assign pc       = r_pc;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign if_valid = r_if_valid;
    assign if_inst  = r_if_inst;
    assign if_pc    = r_if_pc;

endmodule
`default_nettype wire
